// File: rtl/avr_timer_pkg.sv
// Shared constants for the AVR-style Timer/Counter0: default register
// addresses, CS0 clock-select encodings and flag bit positions.
package avr_timer_pkg;

   localparam logic [5:0] DEF_TCNT_ADDR  = 6'd0;
   localparam logic [5:0] DEF_TCCR_ADDR  = 6'd1;
   localparam logic [5:0] DEF_TIMSK_ADDR = 6'd2;
   localparam logic [5:0] DEF_TIFR_ADDR  = 6'd3;

   localparam logic [2:0] CS_STOP     = 3'd0;
   localparam logic [2:0] CS_CLK1     = 3'd1;
   localparam logic [2:0] CS_CLK8     = 3'd2;
   localparam logic [2:0] CS_CLK64    = 3'd3;
   localparam logic [2:0] CS_CLK256   = 3'd4;
   localparam logic [2:0] CS_CLK1024  = 3'd5;
   localparam logic [2:0] CS_T0_FALL  = 3'd6;
   localparam logic [2:0] CS_T0_RISE  = 3'd7;

   localparam int TOV0_BIT  = 0;
   localparam int TOIE0_BIT = 0;

endpackage

// File: rtl/avr_timer_prescaler.sv
// Count-enable generator: free-running 10-bit prescaler, T0 synchronizer
// with edge detection, and the CS0 select that turns them into a tick.
module avr_timer_prescaler
   import avr_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] cs,
   input  logic       t0,
   output logic       tick
);

   logic [9:0] pre;
   logic       t0_meta;
   logic       t0_sync;
   logic       t0_hist;
   logic       t0_rise;
   logic       t0_fall;

   // Prescaler runs from reset onward; clock-select writes never disturb its phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else begin
         pre <= pre + 10'd1;
      end
   end

   // Two flops bring T0 into the clk domain, a third keeps the previous sample for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t0_meta <= 1'b0;
         t0_sync <= 1'b0;
         t0_hist <= 1'b0;
      end else begin
         t0_meta <= t0;
         t0_sync <= t0_meta;
         t0_hist <= t0_sync;
      end
   end

   assign t0_rise = t0_sync & ~t0_hist;
   assign t0_fall = ~t0_sync & t0_hist;

   // Select which event produces the single-cycle count enable.
   always_comb begin
      tick = 1'b0;
      case (cs)
         CS_STOP:    tick = 1'b0;
         CS_CLK1:    tick = 1'b1;
         CS_CLK8:    tick = (pre[2:0] == 3'h7);
         CS_CLK64:   tick = (pre[5:0] == 6'h3F);
         CS_CLK256:  tick = (pre[7:0] == 8'hFF);
         CS_CLK1024: tick = (pre[9:0] == 10'h3FF);
         CS_T0_FALL: tick = t0_fall;
         CS_T0_RISE: tick = t0_rise;
         default:    tick = 1'b0;
      endcase
   end

endmodule

// File: rtl/avr_timer.sv
// AVR Timer/Counter0 on the CPU I/O bus: TCNT0/TCCR0/TIMSK/TIFR registers,
// address decode, tristate read driver and the overflow interrupt request.
module avr_timer
   import avr_timer_pkg::*;
#(
   parameter logic [5:0] TCNT_ADDR  = DEF_TCNT_ADDR,
   parameter logic [5:0] TCCR_ADDR  = DEF_TCCR_ADDR,
   parameter logic [5:0] TIMSK_ADDR = DEF_TIMSK_ADDR,
   parameter logic [5:0] TIFR_ADDR  = DEF_TIFR_ADDR
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] io_addr,
   inout  wire  [7:0] io_data,
   input  logic       io_read,
   input  logic       io_write,
   input  logic       T0,
   output logic       ovf_irq
);

   logic [7:0] tcnt;
   logic [2:0] cs0;
   logic       toie0;
   logic       tov0;
   logic       tick;

   logic       hit_tcnt;
   logic       hit_tccr;
   logic       hit_timsk;
   logic       hit_tifr;
   logic       wr_tcnt;
   logic       wr_tccr;
   logic       wr_timsk;
   logic       wr_tifr;
   logic       tov_set;
   logic       tov_clr;
   logic       rd_hit;
   logic [7:0] rd_data;

   assign hit_tcnt  = (io_addr == TCNT_ADDR);
   assign hit_tccr  = (io_addr == TCCR_ADDR);
   assign hit_timsk = (io_addr == TIMSK_ADDR);
   assign hit_tifr  = (io_addr == TIFR_ADDR);

   assign wr_tcnt  = io_write & hit_tcnt;
   assign wr_tccr  = io_write & hit_tccr;
   assign wr_timsk = io_write & hit_timsk;
   assign wr_tifr  = io_write & hit_tifr;

   // A software write to TCNT0 suppresses both the increment and the overflow it would cause.
   assign tov_set = tick & ~wr_tcnt & (tcnt == 8'hFF);
   assign tov_clr = wr_tifr & io_data[TOV0_BIT];

   avr_timer_prescaler u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .cs   (cs0),
      .t0   (T0),
      .tick (tick)
   );

   // Counter: software write has priority over the tick, otherwise wrap-around increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt <= '0;
      end else if (wr_tcnt) begin
         tcnt <= io_data;
      end else if (tick) begin
         tcnt <= tcnt + 8'd1;
      end
   end

   // Control registers: clock select and overflow interrupt enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs0   <= CS_STOP;
         toie0 <= 1'b0;
      end else begin
         if (wr_tccr) begin
            cs0 <= io_data[2:0];
         end
         if (wr_timsk) begin
            toie0 <= io_data[TOIE0_BIT];
         end
      end
   end

   // Overflow flag: a new overflow beats a simultaneous write-one-to-clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tov0 <= 1'b0;
      end else if (tov_set) begin
         tov0 <= 1'b1;
      end else if (tov_clr) begin
         tov0 <= 1'b0;
      end
   end

   // Read mux: unused register bits read as zero, and a miss leaves the bus alone.
   always_comb begin
      rd_data = '0;
      rd_hit  = 1'b0;
      if (hit_tcnt) begin
         rd_data = tcnt;
         rd_hit  = 1'b1;
      end else if (hit_tccr) begin
         rd_data[2:0] = cs0;
         rd_hit       = 1'b1;
      end else if (hit_timsk) begin
         rd_data[TOIE0_BIT] = toie0;
         rd_hit             = 1'b1;
      end else if (hit_tifr) begin
         rd_data[TOV0_BIT] = tov0;
         rd_hit            = 1'b1;
      end
   end

   assign io_data = (io_read && rd_hit) ? rd_data : 8'bz;
   assign ovf_irq = tov0 & toie0;

endmodule

// File: tb/tb_avr_timer.sv
// Self-checking bench for avr_timer: directed sequence with randomized
// values, expectations derived from edge counts and T0 event arithmetic.
module tb_avr_timer;
   import avr_timer_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] io_addr;
   logic       io_read;
   logic       io_write;
   logic       T0;
   logic       ovf_irq;
   wire  [7:0] io_data;
   logic [7:0] tb_data;
   logic       tb_drive;

   int total = 0;
   int bad   = 0;
   int cyc;
   int last_edge;
   int rise_q[$];
   int fall_q[$];
   logic t0_run;
   logic t0_manual;

   assign io_data = tb_drive ? tb_data : 8'bz;

   always #5 clk = ~clk;

   avr_timer dut (
      .clk      (clk),
      .rst      (rst),
      .io_addr  (io_addr),
      .io_data  (io_data),
      .io_read  (io_read),
      .io_write (io_write),
      .T0       (T0),
      .ovf_irq  (ovf_irq)
   );

   // Number of rising clk edges since reset was released.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // T0 source: toggles every 3 clocks when running and logs the edge where each change should count.
   initial begin : t0_gen
      int cnt;
      cnt = 0;
      T0 = 1'b0;
      forever begin
         @(negedge clk);
         if (t0_run) begin
            cnt++;
            if (cnt == 3) begin
               cnt = 0;
               T0 = ~T0;
               if (T0) rise_q.push_back(cyc + 3);
               else    fall_q.push_back(cyc + 3);
            end
         end else begin
            cnt = 0;
            T0 = t0_manual;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   function automatic int count_land(input bit rising, input int a, input int b);
      int n = 0;
      if (rising) begin
         foreach (rise_q[i]) if (rise_q[i] > a && rise_q[i] <= b) n++;
      end else begin
         foreach (fall_q[i]) if (fall_q[i] > a && fall_q[i] <= b) n++;
      end
      return n;
   endfunction

   function automatic int divisor(input int cs);
      case (cs)
         2:       return 8;
         3:       return 64;
         4:       return 256;
         default: return 1024;
      endcase
   endfunction

   task automatic applyStimulus(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      io_addr  = a;
      tb_data  = d;
      tb_drive = 1'b1;
      io_write = 1'b1;
      @(posedge clk);
      #1;
      io_write  = 1'b0;
      tb_drive  = 1'b0;
      last_edge = cyc;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [5:0] a, input logic [7:0] exp);
      logic [7:0] d;
      io_addr = a;
      io_read = 1'b1;
      #1;
      d = io_data;
      io_read = 1'b0;
      checkOutput(tag, d, exp);
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : main
      int w, s, n, start, ticks, d, ex, cs;
      rst = 1'b0; io_addr = '0; io_read = 1'b0; io_write = 1'b0;
      tb_data = '0; tb_drive = 1'b0; t0_run = 1'b0; t0_manual = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reg("in_reset_tcnt", DEF_TCNT_ADDR, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      wait_edges(2);
      check_reg("reset_tcnt", DEF_TCNT_ADDR, 8'h00);
      check_reg("reset_tccr", DEF_TCCR_ADDR, 8'h00);
      check_reg("reset_timsk", DEF_TIMSK_ADDR, 8'h00);
      check_reg("reset_tifr", DEF_TIFR_ADDR, 8'h00);
      checkOutput("reset_irq", {7'd0, ovf_irq}, 8'h00);

      applyStimulus(DEF_TCCR_ADDR, 8'hFF);
      check_reg("tccr_mask", DEF_TCCR_ADDR, 8'h07);
      io_addr = DEF_TCCR_ADDR; tb_data = 8'hA0; tb_drive = 1'b1;
      #1;
      checkOutput("idle_bus_free", io_data, 8'hA0);
      io_addr = 6'd9; io_read = 1'b1; tb_data = 8'hC3;
      #1;
      checkOutput("miss_bus_free", io_data, 8'hC3);
      io_read = 1'b0; tb_drive = 1'b0;
      applyStimulus(DEF_TIMSK_ADDR, 8'hFF);
      check_reg("timsk_mask", DEF_TIMSK_ADDR, 8'h01);
      applyStimulus(DEF_TCCR_ADDR, 8'h00);

      // clk/1 counting and overflow
      applyStimulus(DEF_TCNT_ADDR, 8'h00);
      applyStimulus(DEF_TIFR_ADDR, 8'h01);
      applyStimulus(DEF_TCCR_ADDR, 8'h01);
      w = last_edge;
      for (int k = 0; k < 3; k++) begin
         wait_edges($urandom_range(1, 60));
         check_reg("cs1_count", DEF_TCNT_ADDR, 8'((cyc - w) % 256));
      end
      wait_edges(255 - (cyc - w));
      check_reg("cs1_pre_wrap", DEF_TCNT_ADDR, 8'hFF);
      check_reg("cs1_pre_tov", DEF_TIFR_ADDR, 8'h00);
      checkOutput("cs1_pre_irq", {7'd0, ovf_irq}, 8'h00);
      wait_edges(1);
      check_reg("cs1_wrap", DEF_TCNT_ADDR, 8'h00);
      check_reg("cs1_tov", DEF_TIFR_ADDR, 8'h01);
      checkOutput("cs1_irq", {7'd0, ovf_irq}, 8'h01);
      applyStimulus(DEF_TIFR_ADDR, 8'h01);
      checkOutput("tifr_clr_irq", {7'd0, ovf_irq}, 8'h00);
      check_reg("tifr_clr", DEF_TIFR_ADDR, 8'h00);
      applyStimulus(DEF_TCCR_ADDR, 8'h00);
      s = last_edge;
      wait_edges(3);
      check_reg("cs0_freeze", DEF_TCNT_ADDR, 8'((s - w) % 256));

      // prescaled clocks; expected ticks come from absolute edge numbers
      for (cs = 2; cs <= 5; cs++) begin
         for (int rep = 0; rep < 2; rep++) begin
            d = divisor(cs);
            start = $urandom_range(0, 255);
            applyStimulus(DEF_TCNT_ADDR, 8'(start));
            applyStimulus(DEF_TIFR_ADDR, 8'h01);
            applyStimulus(DEF_TCCR_ADDR, 8'(cs));
            w = last_edge;
            n = (rep == 0) ? 2047 : int'($urandom_range(40, 1200));
            wait_edges(n);
            applyStimulus(DEF_TCCR_ADDR, 8'h00);
            s = last_edge;
            ticks = s / d - w / d;
            check_reg($sformatf("presc_cs%0d_tcnt", cs), DEF_TCNT_ADDR, 8'((start + ticks) % 256));
            check_reg($sformatf("presc_cs%0d_tov", cs), DEF_TIFR_ADDR, (start + ticks > 255) ? 8'h01 : 8'h00);
         end
      end

      // T0 rising edge latency and polarity
      applyStimulus(DEF_TCNT_ADDR, 8'h00);
      applyStimulus(DEF_TCCR_ADDR, 8'h07);
      t0_manual = 1'b1;
      wait_edges(2);
      check_reg("t0_lat_early", DEF_TCNT_ADDR, 8'h00);
      wait_edges(1);
      check_reg("t0_lat_hit", DEF_TCNT_ADDR, 8'h01);
      t0_manual = 1'b0;
      wait_edges(4);
      check_reg("t0_rise_ignores_fall", DEF_TCNT_ADDR, 8'h01);

      // T0 periodic toggling, rising then falling selection
      for (int p = 0; p < 2; p++) begin
         cs = (p == 0) ? 7 : 6;
         applyStimulus(DEF_TCCR_ADDR, 8'h00);
         applyStimulus(DEF_TCNT_ADDR, 8'h00);
         rise_q.delete();
         fall_q.delete();
         t0_run = 1'b1;
         applyStimulus(DEF_TCCR_ADDR, 8'(cs));
         w = last_edge;
         wait_edges(59);
         applyStimulus(DEF_TCCR_ADDR, 8'h00);
         s = last_edge;
         t0_run = 1'b0;
         ex = count_land(cs == 7, w, s);
         check_reg($sformatf("t0_cs%0d_count", cs), DEF_TCNT_ADDR, 8'(ex));
      end

      // collisions
      applyStimulus(DEF_TCCR_ADDR, 8'h00);
      applyStimulus(DEF_TCNT_ADDR, 8'hFF);
      applyStimulus(DEF_TIFR_ADDR, 8'h01);
      applyStimulus(DEF_TCCR_ADDR, 8'h01);
      applyStimulus(DEF_TCNT_ADDR, 8'h10);
      check_reg("coll_write_wins", DEF_TCNT_ADDR, 8'h10);
      check_reg("coll_no_tov", DEF_TIFR_ADDR, 8'h00);
      applyStimulus(DEF_TCCR_ADDR, 8'h00);
      applyStimulus(DEF_TCNT_ADDR, 8'hFF);
      applyStimulus(DEF_TCCR_ADDR, 8'h01);
      applyStimulus(DEF_TIFR_ADDR, 8'h01);
      check_reg("coll_set_wins", DEF_TIFR_ADDR, 8'h01);
      check_reg("coll_wrap", DEF_TCNT_ADDR, 8'h00);
      applyStimulus(DEF_TIFR_ADDR, 8'hFE);
      check_reg("tifr_write0_keeps", DEF_TIFR_ADDR, 8'h01);

      // asynchronous reset while counting
      applyStimulus(DEF_TCCR_ADDR, 8'h00);
      applyStimulus(DEF_TCNT_ADDR, 8'h80);
      applyStimulus(DEF_TCCR_ADDR, 8'h01);
      w = last_edge;
      wait_edges(4);
      check_reg("pre_rst_tcnt", DEF_TCNT_ADDR, 8'(8'h80 + (cyc - w)));
      checkOutput("pre_rst_irq", {7'd0, ovf_irq}, 8'h01);
      rst = 1'b0;
      #1;
      checkOutput("async_rst_irq", {7'd0, ovf_irq}, 8'h00);
      check_reg("async_rst_tcnt", DEF_TCNT_ADDR, 8'h00);
      check_reg("async_rst_tccr", DEF_TCCR_ADDR, 8'h00);
      check_reg("async_rst_timsk", DEF_TIMSK_ADDR, 8'h00);
      check_reg("async_rst_tifr", DEF_TIFR_ADDR, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      wait_edges(3);
      check_reg("post_rst_stopped", DEF_TCNT_ADDR, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
